id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding unit for the pipelined core.
- Captures decoded rs1/rs2 operands, destination and ALU op from decode, and presents forwarded 64-bit operands to the execute stage.
- The execute stage includes the signed/unsigned set-less-than comparator (compare_bitwise_64).
- Handles stall (hold) and flush (bubble).
- Preserves forwarded values across stalls so that operands are not lost when a producer retires during a hold.

---
 rtl/id_ex_operand_stage_pkg.sv | 25 ++
 rtl/id_ex_operand_stage_fwd_mux.sv | 42 ++++
 rtl/id_ex_operand_stage.sv | 115 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared core definitions: datapath widths, ALU op codes and forward-select codes.
// Op code 0 (ADD into x0) acts as the pipeline NOP.
package core_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;
  localparam int OPW  = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_SLT  = 4'd2;
  localparam logic [OPW-1:0] OP_SLTU = 4'd3;
  localparam logic [OPW-1:0] OP_AND  = 4'd4;
  localparam logic [OPW-1:0] OP_OR   = 4'd5;
  localparam logic [OPW-1:0] OP_XOR  = 4'd6;
  localparam logic [OPW-1:0] OP_SLL  = 4'd7;
  localparam logic [OPW-1:0] OP_SRL  = 4'd8;
  localparam logic [OPW-1:0] OP_SRA  = 4'd9;
  localparam logic [OPW-1:0] OP_NOP  = OP_ADD;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source operand forwarding: picks EX/MEM over MEM/WB over the stored operand.
// x0 is never forwarded, so a producer targeting x0 cannot corrupt a read of x0.
module ex_fwd_mux #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src_addr,
  input  logic [XLEN-1:0] src_data,
  input  logic            exmem_valid,
  input  logic            exmem_wen,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_valid,
  input  logic            memwb_wen,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] fwd_data,
  output logic [1:0]      fwd_sel
);
  import core_pkg::FWD_REG;
  import core_pkg::FWD_MEMWB;
  import core_pkg::FWD_EXMEM;

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_valid && exmem_wen && (exmem_rd != '0) && (exmem_rd == src_addr);
  assign memwb_hit = memwb_valid && memwb_wen && (memwb_rd != '0) && (memwb_rd == src_addr);

  always_comb begin
    fwd_data = src_data;
    fwd_sel  = FWD_REG;
    if (exmem_hit) begin
      fwd_data = exmem_data;
      fwd_sel  = FWD_EXMEM;
    end else if (memwb_hit) begin
      fwd_data = memwb_data;
      fwd_sel  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the execute stage.
// Edge priority is flush > stall > load; ex_valid=0 marks a bubble downstream.
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1_addr,
  input  logic [REGW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [REGW-1:0] id_rd_addr,
  input  logic [OPW-1:0]  id_op,
  input  logic            exmem_valid,
  input  logic            exmem_wen,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_valid,
  input  logic            memwb_wen,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [OPW-1:0]  ex_op,
  output logic [1:0]      ex_fwd1_sel,
  output logic [1:0]      ex_fwd2_sel
);

  logic            valid_q;
  logic [REGW-1:0] rd_q;
  logic [OPW-1:0]  op_q;
  logic [REGW-1:0] rs1_addr_q;
  logic [REGW-1:0] rs2_addr_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  ex_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .src_addr    (rs1_addr_q),
    .src_data    (rs1_q),
    .exmem_valid (exmem_valid),
    .exmem_wen   (exmem_wen),
    .exmem_rd    (exmem_rd),
    .exmem_data  (exmem_data),
    .memwb_valid (memwb_valid),
    .memwb_wen   (memwb_wen),
    .memwb_rd    (memwb_rd),
    .memwb_data  (memwb_data),
    .fwd_data    (rs1_fwd),
    .fwd_sel     (ex_fwd1_sel)
  );

  ex_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .src_addr    (rs2_addr_q),
    .src_data    (rs2_q),
    .exmem_valid (exmem_valid),
    .exmem_wen   (exmem_wen),
    .exmem_rd    (exmem_rd),
    .exmem_data  (exmem_data),
    .memwb_valid (memwb_valid),
    .memwb_wen   (memwb_wen),
    .memwb_rd    (memwb_rd),
    .memwb_data  (memwb_data),
    .fwd_data    (rs2_fwd),
    .fwd_sel     (ex_fwd2_sel)
  );

  // During a stall the forwarded values are written back into the operand
  // registers so a producer that retires mid-hold is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      op_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      op_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (stall) begin
      rs1_q      <= rs1_fwd;
      rs2_q      <= rs2_fwd;
    end else begin
      valid_q    <= id_valid;
      rd_q       <= id_rd_addr;
      op_q       <= id_op;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
      rs1_q      <= id_rs1_data;
      rs2_q      <= id_rs2_data;
    end
  end

  assign ex_valid = valid_q;
  assign ex_rd    = rd_q;
  assign ex_op    = op_q;
  assign ex_rs1   = rs1_fwd;
  assign ex_rs2   = rs2_fwd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomised checks of the ID/EX operand stage: load, forwarding
// priority, x0 guard, stall capture, flush-over-stall and asynchronous reset.
module tb_id_ex_operand_stage;
  import core_pkg::*;

  localparam int EW = 1 + REGW + OPW + 2 * XLEN + 4;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [REGW-1:0] id_rs1_addr;
  logic [REGW-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [REGW-1:0] id_rd_addr;
  logic [OPW-1:0]  id_op;
  logic            exmem_valid;
  logic            exmem_wen;
  logic [REGW-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_data;
  logic            memwb_valid;
  logic            memwb_wen;
  logic [REGW-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [REGW-1:0] ex_rd;
  logic [OPW-1:0]  ex_op;
  logic [1:0]      ex_fwd1_sel;
  logic [1:0]      ex_fwd2_sel;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;

  id_ex_operand_stage #(.XLEN(XLEN), .REGW(REGW), .OPW(OPW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_rd_addr  (id_rd_addr),
    .id_op       (id_op),
    .exmem_valid (exmem_valid),
    .exmem_wen   (exmem_wen),
    .exmem_rd    (exmem_rd),
    .exmem_data  (exmem_data),
    .memwb_valid (memwb_valid),
    .memwb_wen   (memwb_wen),
    .memwb_rd    (memwb_rd),
    .memwb_data  (memwb_data),
    .ex_valid    (ex_valid),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_op       (ex_op),
    .ex_fwd1_sel (ex_fwd1_sel),
    .ex_fwd2_sel (ex_fwd2_sel)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input logic v, input logic [REGW-1:0] rd,
                                         input logic [OPW-1:0] op, input logic [XLEN-1:0] r1,
                                         input logic [XLEN-1:0] r2, input logic [1:0] s1,
                                         input logic [1:0] s2);
    return {v, rd, op, r1, r2, s1, s2};
  endfunction

  // Drivers
  task automatic drive_id(input logic v, input logic [REGW-1:0] a1, input logic [XLEN-1:0] d1,
                          input logic [REGW-1:0] a2, input logic [XLEN-1:0] d2,
                          input logic [REGW-1:0] rd, input logic [OPW-1:0] op);
    id_valid    = v;
    id_rs1_addr = a1;
    id_rs1_data = d1;
    id_rs2_addr = a2;
    id_rs2_data = d2;
    id_rd_addr  = rd;
    id_op       = op;
  endtask

  task automatic drive_exmem(input logic v, input logic w, input logic [REGW-1:0] rd,
                             input logic [XLEN-1:0] d);
    exmem_valid = v;
    exmem_wen   = w;
    exmem_rd    = rd;
    exmem_data  = d;
  endtask

  task automatic drive_memwb(input logic v, input logic w, input logic [REGW-1:0] rd,
                             input logic [XLEN-1:0] d);
    memwb_valid = v;
    memwb_wen   = w;
    memwb_rd    = rd;
    memwb_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic expect_out(input logic v, input logic [REGW-1:0] rd, input logic [OPW-1:0] op,
                            input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                            input logic [1:0] s1, input logic [1:0] s2);
    exp_q.push_back(pack(v, rd, op, r1, r2, s1, s2));
  endtask

  task automatic check_out(input string tag);
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    obs = pack(ex_valid, ex_rd, ex_op, ex_rs1, ex_rs2, ex_fwd1_sel, ex_fwd2_sel);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Reference forwarding model for the randomised section
  function automatic logic [XLEN+1:0] model_fwd(input logic [REGW-1:0] a, input logic [XLEN-1:0] d);
    if (exmem_valid && exmem_wen && exmem_rd == a && a != 0) return {FWD_EXMEM, exmem_data};
    if (memwb_valid && memwb_wen && memwb_rd == a && a != 0) return {FWD_MEMWB, memwb_data};
    return {FWD_REG, d};
  endfunction

  initial begin
    logic [XLEN+1:0] f1;
    logic [XLEN+1:0] f2;
    logic [REGW-1:0] ra1, ra2, rrd;
    logic [XLEN-1:0] rd1, rd2;
    logic            rv;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    drive_id(1'b0, '0, '0, '0, '0, '0, OP_NOP);
    drive_exmem(1'b0, 1'b0, '0, '0);
    drive_memwb(1'b0, 1'b0, '0, '0);
    #23;
    expect_out(1'b0, '0, '0, '0, '0, FWD_REG, FWD_REG);
    check_out("reset");
    rst_n = 1'b1;
    #4;

    // Plain load, no hazards
    drive_id(1'b1, 5'd1, -64'sd15, 5'd2, 64'd16, 5'd3, OP_SLT);
    expect_out(1'b1, 5'd3, OP_SLT, 64'hFFFF_FFFF_FFFF_FFF1, 64'h10, FWD_REG, FWD_REG);
    tick();
    check_out("load_nohaz");

    // EX/MEM beats MEM/WB, then MEM/WB alone, then wen=0 disables it
    drive_id(1'b1, 5'd7, 64'd1, 5'd8, 64'd2, 5'd4, OP_ADD);
    drive_exmem(1'b1, 1'b1, 5'd7, 64'd32);
    drive_memwb(1'b1, 1'b1, 5'd7, 64'd99);
    expect_out(1'b1, 5'd4, OP_ADD, 64'd32, 64'd2, FWD_EXMEM, FWD_REG);
    tick();
    check_out("prio_exmem");
    exmem_valid = 1'b0;
    #1;
    expect_out(1'b1, 5'd4, OP_ADD, 64'd99, 64'd2, FWD_MEMWB, FWD_REG);
    check_out("prio_memwb");
    memwb_wen = 1'b0;
    #1;
    expect_out(1'b1, 5'd4, OP_ADD, 64'd1, 64'd2, FWD_REG, FWD_REG);
    check_out("memwb_wen_off");

    // Both sources hit the same producer
    drive_memwb(1'b0, 1'b0, '0, '0);
    drive_id(1'b1, 5'd9, 64'd11, 5'd9, 64'd12, 5'd9, OP_SUB);
    drive_exmem(1'b1, 1'b1, 5'd9, 64'hDEAD_BEEF);
    expect_out(1'b1, 5'd9, OP_SUB, 64'hDEAD_BEEF, 64'hDEAD_BEEF, FWD_EXMEM, FWD_EXMEM);
    tick();
    check_out("both_same_prod");

    // x0 guard
    drive_id(1'b1, 5'd6, 64'd6, 5'd0, 64'h1234, 5'd1, OP_SLTU);
    drive_exmem(1'b1, 1'b1, 5'd0, 64'h8000_0000_0000_0000);
    drive_memwb(1'b1, 1'b1, 5'd0, 64'h7777);
    expect_out(1'b1, 5'd1, OP_SLTU, 64'd6, 64'h1234, FWD_REG, FWD_REG);
    tick();
    check_out("x0_guard");

    // Invalid slot still loads its fields
    drive_exmem(1'b0, 1'b0, '0, '0);
    drive_memwb(1'b0, 1'b0, '0, '0);
    drive_id(1'b0, 5'd12, 64'hAA, 5'd13, 64'hBB, 5'd14, OP_XOR);
    expect_out(1'b0, 5'd14, OP_XOR, 64'hAA, 64'hBB, FWD_REG, FWD_REG);
    tick();
    check_out("bubble_load");

    // Stall capture of a retiring producer
    drive_id(1'b1, 5'd5, 64'd0, 5'd3, 64'd3, 5'd10, OP_SUB);
    expect_out(1'b1, 5'd10, OP_SUB, 64'd0, 64'd3, FWD_REG, FWD_REG);
    tick();
    check_out("stall_preload");
    drive_memwb(1'b1, 1'b1, 5'd5, -64'sd16);
    #1;
    expect_out(1'b1, 5'd10, OP_SUB, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, FWD_MEMWB, FWD_REG);
    check_out("stall_fwd_live");
    stall = 1'b1;
    drive_id(1'b0, 5'd31, 64'h5555, 5'd30, 64'h6666, 5'd31, OP_SRA);
    tick();
    memwb_valid = 1'b0;
    #1;
    expect_out(1'b1, 5'd10, OP_SUB, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, FWD_REG, FWD_REG);
    check_out("stall_captured");
    expect_out(1'b1, 5'd10, OP_SUB, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, FWD_REG, FWD_REG);
    tick();
    check_out("stall_hold2");

    // Flush wins over stall
    flush = 1'b1;
    drive_exmem(1'b1, 1'b1, 5'd5, 64'h99);
    expect_out(1'b0, '0, '0, '0, '0, FWD_REG, FWD_REG);
    tick();
    check_out("flush_over_stall");
    flush = 1'b0;
    stall = 1'b0;
    drive_exmem(1'b0, 1'b0, '0, '0);

    // Asynchronous reset in the middle of a stall
    drive_id(1'b1, 5'd2, 64'h55, 5'd4, 64'h66, 5'd7, OP_ADD);
    expect_out(1'b1, 5'd7, OP_ADD, 64'h55, 64'h66, FWD_REG, FWD_REG);
    tick();
    check_out("pre_reset_load");
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(1'b0, '0, '0, '0, '0, FWD_REG, FWD_REG);
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    drive_id(1'b1, 5'd3, 64'hABCD, 5'd4, 64'h1, 5'd8, OP_OR);
    expect_out(1'b1, 5'd8, OP_OR, 64'hABCD, 64'h1, FWD_REG, FWD_REG);
    tick();
    check_out("post_reset_load");

    // Randomised loads with producers on a small register window
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra1 = REGW'($urandom_range(0, 3));
      ra2 = REGW'($urandom_range(0, 3));
      rrd = REGW'($urandom_range(1, 31));
      rd1 = {$urandom, $urandom};
      rd2 = {$urandom, $urandom};
      rv  = 1'($urandom_range(0, 1));
      drive_id(rv, ra1, rd1, ra2, rd2, rrd, OP_AND);
      drive_exmem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  REGW'($urandom_range(0, 3)), {$urandom, $urandom});
      drive_memwb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  REGW'($urandom_range(0, 3)), {$urandom, $urandom});
      f1 = model_fwd(ra1, rd1);
      f2 = model_fwd(ra2, rd2);
      expect_out(rv, rrd, OP_AND, f1[XLEN-1:0], f2[XLEN-1:0], f1[XLEN+1:XLEN], f2[XLEN+1:XLEN]);
      tick();
      check_out($sformatf("rand_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
